// File: rtl/cr_kme_thresh_fifo.sv
// Show-ahead flop FIFO with a programmable early-stall threshold, occupancy
// outputs, high-water mark and registered overflow/underflow pulses.
module cr_kme_thresh_fifo #(
  parameter int DATA_SIZE   = 128,
  parameter int FIFO_DEPTH  = 4,
  parameter int STALL_AT    = 0,
  parameter int OVERRIDE_EN = 0,
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_SIZE-1:0] fifo_in,
  input  logic                 fifo_in_valid,
  output logic                 fifo_in_stall,
  input  logic                 fifo_in_stall_override,
  output logic [DATA_SIZE-1:0] fifo_out,
  output logic                 fifo_out_valid,
  input  logic                 fifo_out_ack,
  input  logic                 clear,
  output logic [CNT_W-1:0]     used_slots,
  output logic [CNT_W-1:0]     free_slots,
  output logic [CNT_W-1:0]     high_water,
  output logic                 fifo_overflow,
  output logic                 fifo_underflow
);

  localparam int               PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] STALL_CNT = CNT_W'(STALL_AT);
  localparam bit               OVR_ON    = (OVERRIDE_EN != 0);

  logic [DATA_SIZE-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     rptr, wptr;
  logic [CNT_W-1:0]     count, count_next, hw_next;
  logic                 full, empty, wen, ren;

  // Pointers wrap by explicit compare so any depth works, not just 2^n.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign full           = (count == DEPTH_CNT);
  assign empty          = (count == '0);
  assign ren            = !empty && fifo_out_ack;
  assign wen            = fifo_in_valid && (!full || ren);

  assign fifo_out       = mem[rptr];
  assign fifo_out_valid = !empty;
  assign used_slots     = count;
  assign free_slots     = DEPTH_CNT - count;
  assign fifo_in_stall  = (free_slots <= STALL_CNT) && !(OVR_ON && fifo_in_stall_override);

  // NOTE: combinational blocks use blocking '=' with a default first, so no latch is inferred.
  always_comb begin
    count_next = count;
    if (clear)             count_next = '0;
    else if (wen && !ren)  count_next = count + 1'b1;
    else if (ren && !wen)  count_next = count - 1'b1;
    hw_next = high_water;
    if (clear)                        hw_next = '0;
    else if (count_next > high_water) hw_next = count_next;
  end

  // NOTE: sequential blocks use non-blocking '<='; control state gets the async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr           <= '0;
      wptr           <= '0;
      count          <= '0;
      high_water     <= '0;
      fifo_overflow  <= 1'b0;
      fifo_underflow <= 1'b0;
    end else begin
      count      <= count_next;
      high_water <= hw_next;
      if (clear) begin
        rptr           <= '0;
        wptr           <= '0;
        fifo_overflow  <= 1'b0;
        fifo_underflow <= 1'b0;
      end else begin
        if (wen) wptr <= next_ptr(wptr);
        if (ren) rptr <= next_ptr(rptr);
        fifo_overflow  <= fifo_in_valid && full && !ren;
        fifo_underflow <= fifo_out_ack && empty;
      end
    end
  end

  // NOTE: payload storage is deliberately not reset; valid is derived from count alone.
  always_ff @(posedge clk) begin
    if (wen && !clear) mem[wptr] <= fifo_in;
  end

endmodule

// File: tb/tb_cr_kme_thresh_fifo.sv
// Directed bench for cr_kme_thresh_fifo (8b x 5 deep, stall at free<=1);
// a second instance with the stall override enabled shares the same inputs.
module tb_cr_kme_thresh_fifo;

  localparam int W = 8;
  localparam int D = 5;
  localparam int C = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] fifo_in;
  logic         fifo_in_valid, ovr, fifo_out_ack, clear;

  logic [W-1:0] a_out, b_out;
  logic         a_stall, a_valid, a_ovf, a_unf;
  logic         b_stall, b_valid, b_ovf, b_unf;
  logic [C-1:0] a_used, a_free, a_hw, b_used, b_free, b_hw;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cr_kme_thresh_fifo #(.DATA_SIZE(W), .FIFO_DEPTH(D), .STALL_AT(1), .OVERRIDE_EN(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .fifo_in(fifo_in), .fifo_in_valid(fifo_in_valid),
    .fifo_in_stall(a_stall), .fifo_in_stall_override(ovr), .fifo_out(a_out),
    .fifo_out_valid(a_valid), .fifo_out_ack(fifo_out_ack), .clear(clear),
    .used_slots(a_used), .free_slots(a_free), .high_water(a_hw),
    .fifo_overflow(a_ovf), .fifo_underflow(a_unf));

  cr_kme_thresh_fifo #(.DATA_SIZE(W), .FIFO_DEPTH(D), .STALL_AT(1), .OVERRIDE_EN(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .fifo_in(fifo_in), .fifo_in_valid(fifo_in_valid),
    .fifo_in_stall(b_stall), .fifo_in_stall_override(ovr), .fifo_out(b_out),
    .fifo_out_valid(b_valid), .fifo_out_ack(fifo_out_ack), .clear(clear),
    .used_slots(b_used), .free_slots(b_free), .high_water(b_hw),
    .fifo_overflow(b_ovf), .fifo_underflow(b_unf));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] d);
    fifo_in_valid = 1'b1;
    fifo_in       = d;
    tick();
    fifo_in_valid = 1'b0;
  endtask

  task automatic idle_status(input string tag, input int used, input int hw);
    check({tag, "_used"}, 32'(a_used), 32'(used));
    check({tag, "_free"}, 32'(a_free), 32'(D - used));
    check({tag, "_hw"},   32'(a_hw),   32'(hw));
    check({tag, "_vld"},  32'(a_valid), 32'(used != 0));
  endtask

  initial begin
    rst_n = 1'b0; fifo_in = '0; fifo_in_valid = 1'b0; ovr = 1'b0;
    fifo_out_ack = 1'b0; clear = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // 1: reset state, then one write with one cycle of latency
    idle_status("rst", 0, 0);
    check("rst_stall", 32'(a_stall), 0);
    check("rst_ovf",   32'(a_ovf),   0);
    check("rst_unf",   32'(a_unf),   0);
    fifo_in_valid = 1'b1; fifo_in = 8'hA1;
    #1;
    check("no_bypass", 32'(a_valid), 0);
    tick();
    fifo_in_valid = 1'b0;
    check("t1_vld", 32'(a_valid), 1);
    check("t1_out", 32'(a_out), 32'hA1);
    check("t1_used", 32'(a_used), 1);
    fifo_out_ack = 1'b1; tick(); fifo_out_ack = 1'b0;
    idle_status("t1_pop", 0, 1);

    // 2: fill, stall threshold, overflow on the 6th write
    for (int i = 0; i < 4; i++) begin
      push(8'hB0 + 8'(i));
      check($sformatf("t2_used%0d", i), 32'(a_used), 32'(i + 1));
      check($sformatf("t2_stall%0d", i), 32'(a_stall), 32'(i == 3));
    end
    push(8'hB4);
    check("t2_full_free", 32'(a_free), 0);
    check("t2_full_stall", 32'(a_stall), 1);
    push(8'hEE);
    check("t2_ovf", 32'(a_ovf), 1);
    check("t2_ovf_used", 32'(a_used), 5);
    tick();
    check("t2_ovf_pulse", 32'(a_ovf), 0);
    check("t2_head", 32'(a_out), 32'hB0);
    fifo_out_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t2_drain%0d", i), 32'(a_out), 32'hB0 + 32'(i));
      tick();
    end
    fifo_out_ack = 1'b0;
    idle_status("t2_empty", 0, 5);

    // 3: full FIFO streaming with simultaneous push/pop; pointers wrap twice
    for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i));
    fifo_out_ack = 1'b1; fifo_in_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      fifo_in = 8'hC5 + 8'(k);
      check($sformatf("t3_head%0d", k), 32'(a_out), 32'hC0 + 32'(k));
      tick();
      check($sformatf("t3_used%0d", k), 32'(a_used), 5);
      check($sformatf("t3_ovf%0d", k), 32'(a_ovf), 0);
    end
    fifo_in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t3_drain%0d", i), 32'(a_out), 32'hCC + 32'(i));
      tick();
    end
    fifo_out_ack = 1'b0;
    check("t3_empty", 32'(a_valid), 0);

    // 4: ack while empty
    fifo_out_ack = 1'b1; tick(); fifo_out_ack = 1'b0;
    check("t4_unf", 32'(a_unf), 1);
    check("t4_used", 32'(a_used), 0);
    tick();
    check("t4_unf_pulse", 32'(a_unf), 0);
    push(8'hE5);
    check("t4_ptr_head", 32'(a_out), 32'hE5);
    check("t4_ptr_used", 32'(a_used), 1);

    // 6: clear wins over a concurrent push/pop and zeroes the high-water mark
    clear = 1'b1; tick(); clear = 1'b0;
    idle_status("t6_pre", 0, 0);
    for (int i = 0; i < 3; i++) push(8'h60 + 8'(i));
    idle_status("t6_fill", 3, 3);
    clear = 1'b1; fifo_in_valid = 1'b1; fifo_in = 8'h6F; fifo_out_ack = 1'b1;
    tick();
    clear = 1'b0; fifo_in_valid = 1'b0; fifo_out_ack = 1'b0;
    idle_status("t6_clr", 0, 0);
    check("t6_ovf", 32'(a_ovf), 0);
    check("t6_unf", 32'(a_unf), 0);
    push(8'h77);
    check("t6_after", 32'(a_out), 32'h77);

    // 5: override masks stall only on the OVERRIDE_EN=1 instance
    clear = 1'b1; tick(); clear = 1'b0;
    for (int i = 0; i < 4; i++) push(8'h50 + 8'(i));
    check("t5_b_stall_pre", 32'(b_stall), 1);
    ovr = 1'b1;
    #1;
    check("t5_b_stall_ovr", 32'(b_stall), 0);
    check("t5_a_stall_ovr", 32'(a_stall), 1);
    push(8'h54);
    check("t5_b_used", 32'(b_used), 5);
    check("t5_b_stall_full", 32'(b_stall), 0);
    push(8'h55);
    check("t5_b_ovf", 32'(b_ovf), 1);
    check("t5_b_used_ovf", 32'(b_used), 5);
    check("t5_b_head", 32'(b_out), 32'h50);
    ovr = 1'b0;
    fifo_out_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t5_b_drain%0d", i), 32'(b_out), 32'h50 + 32'(i));
      tick();
    end
    fifo_out_ack = 1'b0;
    check("t5_b_empty", 32'(b_valid), 0);

    // Reset mid-operation discards contents
    push(8'h91); push(8'h92);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_used", 32'(a_used), 0);
    check("rst_mid_vld", 32'(a_valid), 0);
    check("rst_mid_hw", 32'(a_hw), 0);
    tick();
    rst_n = 1'b1;
    tick();
    push(8'h93);
    check("rst_post_out", 32'(a_out), 32'h93);
    check("rst_post_used", 32'(a_used), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
